mem_quad_dma: RTL and testbench

Four-lane load/store sequencer that drives the 4-port 256×16 data memory (addrN/write_enN/datainN in, dataoutN out, 1-cycle registered read) on behalf of the matrix-multiply datapath. On a command it either reads or writes `count` beats of four 16-bit words, one beat per cycle. Lane i always uses memory port i. Read beats leave on a 64-bit valid/ready stream and write beats arrive on one. It sits between the matrix engine's operand/result streams and the data memory.

---
 rtl/mem_quad_dma.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_quad_dma.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_quad_dma.sv
// Four-lane load/store sequencer for the 4-port 256x16 data memory.
// Optional feature macro: DMA_STRIDE_EN (adds the stride port; otherwise the beat step is 4).

// Small synchronous FIFO; head is presented combinationally from storage.
// Latency: a push is visible at the head the following cycle.
// Backpressure: pops on pop_vld && pop_rdy; the producer guarantees it never pushes when full.
module mem_quad_dma_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             push_vld,
    input  logic [WIDTH-1:0]                 push_dat,
    output logic                             pop_vld,
    input  logic                             pop_rdy,
    output logic [WIDTH-1:0]                 pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]       level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign pop_vld = (level != '0);
    assign pop     = pop_vld && pop_rdy;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            level <= level + LW'(push_vld) - LW'(pop);
        end
    end
endmodule

// Sequences count beats of four 16-bit words between the data memory and 64-bit streams.
// Latency: read beat 0 reaches out_valid 3 cycles after acceptance; a write beat hits memory 1 cycle after acceptance.
// Backpressure: read issue is credit-limited by the 2-entry output FIFO; in_ready drops once count beats are taken.
module mem_quad_dma #(
    parameter int BEAT_MAX = 64
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             dir,
    input  logic [7:0]                       base_addr,
    input  logic [$clog2(BEAT_MAX+1)-1:0]    count,
`ifdef DMA_STRIDE_EN
    input  logic [7:0]                       stride,
`endif
    output logic [7:0]                       addr0,
    output logic [7:0]                       addr1,
    output logic [7:0]                       addr2,
    output logic [7:0]                       addr3,
    output logic                             write_en0,
    output logic                             write_en1,
    output logic                             write_en2,
    output logic                             write_en3,
    output logic [15:0]                      datain0,
    output logic [15:0]                      datain1,
    output logic [15:0]                      datain2,
    output logic [15:0]                      datain3,
    input  logic [15:0]                      dataout0,
    input  logic [15:0]                      dataout1,
    input  logic [15:0]                      dataout2,
    input  logic [15:0]                      dataout3,
    output logic [63:0]                      out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic [63:0]                      in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             busy,
    output logic                             done
);
    localparam int CW = $clog2(BEAT_MAX+1);

    typedef enum logic [1:0] {IDLE, RD, RDRAIN, WR} state_t;

    typedef struct packed {
        logic [CW-1:0] beats;
        logic [7:0]    step;
    } cmd_t;

    state_t        state;
    cmd_t          cmd;
    logic [7:0]    step_in;
    logic [7:0]    beat_addr;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] pop_cnt;
    logic          rd_v1;
    logic          rd_v2;
    logic [7:0]    addr_q [4];
    logic [15:0]   din_q [4];
    logic [3:0]    we_q;
    logic [1:0]    fifo_level;
    logic [63:0]   rd_beat;
    logic          pop;
    logic [2:0]    occ;
    logic          issue_ok;

`ifdef DMA_STRIDE_EN
    assign step_in = stride;
`else
    assign step_in = 8'd4;
`endif

    assign addr0     = addr_q[0];
    assign addr1     = addr_q[1];
    assign addr2     = addr_q[2];
    assign addr3     = addr_q[3];
    assign datain0   = din_q[0];
    assign datain1   = din_q[1];
    assign datain2   = din_q[2];
    assign datain3   = din_q[3];
    assign write_en0 = we_q[0];
    assign write_en1 = we_q[1];
    assign write_en2 = we_q[2];
    assign write_en3 = we_q[3];

    assign rd_beat  = {dataout3, dataout2, dataout1, dataout0};
    assign pop      = out_valid && out_ready;
    // rd_v1: address on the memory bus this cycle; rd_v2: read data on dataoutN this cycle.
    assign occ      = 3'(fifo_level) + 3'(rd_v1) + 3'(rd_v2) - 3'(pop);
    assign issue_ok = (occ <= 3'd1);
    assign in_ready = (state == WR) && (beat_cnt != cmd.beats);

    mem_quad_dma_fifo #(
        .WIDTH (64),
        .DEPTH (2)
    ) u_out_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (rd_v2),
        .push_dat (rd_beat),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (out_data),
        .level    (fifo_level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cmd       <= '0;
            beat_addr <= '0;
            beat_cnt  <= '0;
            pop_cnt   <= '0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            we_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                addr_q[i] <= '0;
                din_q[i]  <= '0;
            end
        end else begin
            done  <= 1'b0;
            we_q  <= '0;
            rd_v1 <= 1'b0;
            rd_v2 <= rd_v1;
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd.beats <= count;
                        cmd.step  <= step_in;
                        pop_cnt   <= '0;
                        if (count == '0) begin
                            beat_cnt <= '0;
                            done     <= 1'b1;
                        end else if (!dir) begin
                            // Beat 0 issues on acceptance so its address is on the bus next cycle.
                            state     <= RD;
                            busy      <= 1'b1;
                            rd_v1     <= 1'b1;
                            beat_cnt  <= CW'(1);
                            beat_addr <= base_addr + step_in;
                            for (int i = 0; i < 4; i++) begin
                                addr_q[i] <= base_addr + 8'(i);
                            end
                        end else begin
                            state     <= WR;
                            busy      <= 1'b1;
                            beat_cnt  <= '0;
                            beat_addr <= base_addr;
                        end
                    end
                end
                RD: begin
                    if (beat_cnt == cmd.beats) begin
                        state <= RDRAIN;
                    end else if (issue_ok) begin
                        rd_v1     <= 1'b1;
                        beat_cnt  <= beat_cnt + 1'b1;
                        beat_addr <= beat_addr + cmd.step;
                        for (int i = 0; i < 4; i++) begin
                            addr_q[i] <= beat_addr + 8'(i);
                        end
                    end
                    if (pop) begin
                        pop_cnt <= pop_cnt + 1'b1;
                    end
                end
                RDRAIN: begin
                    if (pop) begin
                        pop_cnt <= pop_cnt + 1'b1;
                        if (pop_cnt + CW'(1) == cmd.beats) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (in_valid && in_ready) begin
                        we_q      <= 4'hF;
                        beat_cnt  <= beat_cnt + 1'b1;
                        beat_addr <= beat_addr + cmd.step;
                        for (int i = 0; i < 4; i++) begin
                            addr_q[i] <= beat_addr + 8'(i);
                            din_q[i]  <= in_data[16*i +: 16];
                        end
                    end else if (beat_cnt == cmd.beats && we_q[0]) begin
                        // The final write is on the bus this cycle.
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_quad_dma.sv
// Self-checking bench for mem_quad_dma with a behavioural 4-port memory and a word-level reference memory.
module tb_mem_quad_dma;
    logic        clock;
    logic        reset;
    logic        start;
    logic        dir;
    logic [7:0]  base_addr;
    logic [6:0]  count;
`ifdef DMA_STRIDE_EN
    logic [7:0]  stride;
`endif
    logic [7:0]  addr0, addr1, addr2, addr3;
    logic        write_en0, write_en1, write_en2, write_en3;
    logic [15:0] datain0, datain1, datain2, datain3;
    logic [15:0] dataout0, dataout1, dataout2, dataout3;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem     [256];
    logic [15:0] exp_mem [256];
    logic [63:0] wbeat   [64];

    mem_quad_dma dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dir       (dir),
        .base_addr (base_addr),
        .count     (count),
`ifdef DMA_STRIDE_EN
        .stride    (stride),
`endif
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .addr3     (addr3),
        .write_en0 (write_en0),
        .write_en1 (write_en1),
        .write_en2 (write_en2),
        .write_en3 (write_en3),
        .datain0   (datain0),
        .datain1   (datain1),
        .datain2   (datain2),
        .datain3   (datain3),
        .dataout0  (dataout0),
        .dataout1  (dataout1),
        .dataout2  (dataout2),
        .dataout3  (dataout3),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 4-port memory with one-cycle registered read.
    always @(posedge clock) begin
        dataout0 <= mem[addr0];
        dataout1 <= mem[addr1];
        dataout2 <= mem[addr2];
        dataout3 <= mem[addr3];
        if (write_en0) mem[addr0] <= datain0;
        if (write_en1) mem[addr1] <= datain1;
        if (write_en2) mem[addr2] <= datain2;
        if (write_en3) mem[addr3] <= datain3;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s cycle budget exhausted", tag);
    endtask

    function automatic int lane_word(input logic [7:0] base, input int k, input logic [7:0] step, input int i);
        return (int'(base) + k * int'(step) + i) & 255;
    endfunction

    function automatic logic [31:0] addr_vec(input logic [7:0] base, input int k, input logic [7:0] step);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'(lane_word(base, k, step, i));
        return v;
    endfunction

    function automatic logic [63:0] exp_beat(input logic [7:0] base, input int k, input logic [7:0] step);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[16*i +: 16] = exp_mem[lane_word(base, k, step, i)];
        return v;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_addr"}, {addr3, addr2, addr1, addr0}, 32'h0);
        check({tag, "_datain"}, {datain3, datain2, datain1, datain0}, 64'h0);
        check({tag, "_ctl"}, {write_en3, write_en2, write_en1, write_en0, out_valid, in_ready, busy, done}, 8'h0);
        check({tag, "_out_data"}, out_data, 64'h0);
    endtask

    task automatic scramble_cmd();
        base_addr = 8'($urandom);
        count     = 7'($urandom_range(64));
        dir       = 1'($urandom);
`ifdef DMA_STRIDE_EN
        stride    = 8'($urandom);
`endif
    endtask

    task automatic run_write(input logic [7:0] base, input int n, input logic [7:0] step, input int gap);
        int   cyc, k, pend_k, last_w;
        logic pend, exp_done;
        dir       = 1'b1;
        base_addr = base;
        count     = 7'(n);
`ifdef DMA_STRIDE_EN
        stride    = step;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_cmd();
        cyc = 1; k = 0; pend = 1'b0; pend_k = 0;
        last_w = (n == 0) ? 0 : -10;
        forever begin
            exp_done = (k == n) && (cyc == last_w + 1);
            check("wr_ctl", {write_en3, write_en2, write_en1, write_en0, done, busy, in_ready},
                  {(pend ? 4'hF : 4'h0), exp_done, (n > 0) && !exp_done, k < n});
            if (pend) begin
                check("wr_addr", {addr3, addr2, addr1, addr0}, addr_vec(base, pend_k, step));
                check("wr_data", {datain3, datain2, datain1, datain0}, wbeat[pend_k]);
                if (pend_k == n - 1) last_w = cyc;
                pend = 1'b0;
            end
            if (exp_done) break;
            if (cyc > 3000) begin
                timeout("wr_done");
                break;
            end
            in_valid = (k < n) && ($urandom_range(99) >= gap);
            in_data  = (k < n) ? wbeat[k] : {$urandom, $urandom};
            if (in_valid) begin
                pend = 1'b1;
                pend_k = k;
                for (int i = 0; i < 4; i++) exp_mem[lane_word(base, k, step, i)] = wbeat[k][16*i +: 16];
                k++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_read(input logic [7:0] base, input int n, input logic [7:0] step,
                            input int mode, input int abort_n, input bit extra_start);
        logic [63:0] expq [$];
        int   cyc, popk, last_pop;
        logic exp_done;
        for (int k = 0; k < n; k++) expq.push_back(exp_beat(base, k, step));
        dir       = 1'b0;
        base_addr = base;
        count     = 7'(n);
`ifdef DMA_STRIDE_EN
        stride    = step;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_cmd();
        cyc = 1; popk = 0;
        last_pop = (n == 0) ? 0 : -10;
        forever begin
            exp_done = (popk == n) && (cyc == last_pop + 1);
            check("rd_ctl", {write_en3, write_en2, write_en1, write_en0, done, busy, in_ready},
                  {4'h0, exp_done, (n > 0) && !exp_done, 1'b0});
            if (cyc == 1 && n > 0) check("rd_addr_beat0", {addr3, addr2, addr1, addr0}, addr_vec(base, 0, step));
            if (cyc <= 2 || popk == n) check("rd_valid_low", out_valid, 1'b0);
            if (cyc == 3 && n > 0) check("rd_valid_cycle3", out_valid, 1'b1);
            if (exp_done) break;
            if (cyc > 3000) begin
                timeout("rd_done");
                break;
            end
            if (out_valid && popk < n) check("rd_data", out_data, expq[popk]);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom);
            endcase
            start = extra_start && (cyc == 4);
            if (start) begin
                dir   = 1'b1;
                count = 7'd5;
            end
            if (out_valid && out_ready && popk < n) begin
                popk++;
                last_pop = cyc;
                if (popk == abort_n) begin
                    reset = 1'b1;
                    tick();
                    check_reset("abort");
                    reset = 1'b0;
                    for (int j = 0; j < 6; j++) begin
                        tick();
                        check("abort_quiet", {out_valid, write_en3, write_en2, write_en1, write_en0, busy, done}, 7'h0);
                    end
                    out_ready = 1'b0;
                    return;
                end
            end
            tick();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] rbase;
        int         rn;
        reset = 1'b1; start = 1'b0; dir = 1'b0; base_addr = 8'h0; count = 7'd0;
        in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b0;
`ifdef DMA_STRIDE_EN
        stride = 8'd4;
`endif
        tick();
        tick();
        check_reset("reset");
        reset = 1'b0;

        // Contiguous write then read back
        wbeat[0] = 64'h0004_0003_0002_0001;
        wbeat[1] = 64'h0008_0007_0006_0005;
        run_write(8'h10, 2, 8'd4, 0);
        run_read(8'h10, 2, 8'd4, 0, -1, 1'b0);

        // Backpressure 1,0,0 pattern on an 8-beat read
        for (int k = 0; k < 8; k++) wbeat[k] = {$urandom, $urandom};
        run_write(8'h40, 8, 8'd4, 40);
        run_read(8'h40, 8, 8'd4, 1, -1, 1'b0);

        // Address wrap at the top of memory
        wbeat[0] = {$urandom, $urandom};
        run_write(8'hFE, 1, 8'd4, 0);
        run_read(8'hFE, 1, 8'd4, 0, -1, 1'b0);

        // Zero-length commands
        run_write(8'h33, 0, 8'd4, 0);
        run_read(8'h77, 0, 8'd4, 0, -1, 1'b0);

        // Second start during a read is ignored
        run_read(8'h40, 8, 8'd4, 2, -1, 1'b1);

        // Reset after three pops aborts the read
        run_read(8'h40, 8, 8'd4, 0, 3, 1'b0);

        // Randomised round trips, first one at the maximum length
        for (int it = 0; it < 3; it++) begin
            rbase = 8'($urandom);
            rn    = (it == 0) ? 64 : int'($urandom_range(1, 64));
            for (int k = 0; k < rn; k++) wbeat[k] = {$urandom, $urandom};
            run_write(rbase, rn, 8'd4, 30);
            run_read(rbase, rn, 8'd4, 2, -1, 1'b0);
        end

`ifdef DMA_STRIDE_EN
        for (int k = 0; k < 4; k++) wbeat[k] = {$urandom, $urandom};
        run_write(8'h00, 3, 8'd16, 0);
        run_read(8'h00, 3, 8'd16, 0, -1, 1'b0);
        run_write(8'h80, 4, 8'd2, 20);
        run_read(8'h80, 4, 8'd2, 2, -1, 1'b0);
        run_read(8'h80, 3, 8'd0, 0, -1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
